// File: rtl/uart_tx_core.sv
// uart_tx_core: byte FIFO + 8N1/8N2 serialiser, LSB first, tx idles high.
// Ports: clk, rst_n, tx_data/tx_valid/tx_ready in, tx/tx_busy/fifo_level out.
// Optional: define UART_TX_PARITY_EN for an even-parity bit after the data.
module uart_tx_core #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [7:0]      shift;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic            parity;
`endif

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            stop_end;
  logic [7:0]      head;

  assign tx_ready   = (level != FULL_LVL);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  // stop_end: last cycle of the final stop bit
  assign stop_end   = (state == STOP) && bit_end &&
                      (bit_cnt == STOP_LAST);
  assign pop        = (level != '0) &&
                      ((state == IDLE) || stop_end);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign tx_busy    = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head;
`ifdef UART_TX_PARITY_EN
            parity   <= ^head;
`endif
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            tx       <= shift[0];
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              // back-to-back frames: no idle gap
              if (pop) begin
                shift  <= head;
`ifdef UART_TX_PARITY_EN
                parity <= ^head;
`endif
                tx     <= 1'b0;
                state  <= START;
              end else begin
                tx     <= 1'b1;
                state  <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench with a line monitor and byte scoreboard.
// BAUD_DIV=4, FIFO_DEPTH=4, STOP_BITS=1.
module tb_uart_tx_core;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int got_cnt = 0;
  logic mon_en = 1'b0;
  logic mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_core #(
    .BAUD_DIV(BD),
    .FIFO_DEPTH(4),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .tx_busy(tx_busy),
    .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Line monitor: samples the middle of each bit period.
  initial begin : monitor
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    int         st;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        st = cyc;
        mon_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BD) @(negedge clk);
        p = tx;
`endif
        repeat (BD) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        got_cnt++;
        starts.push_back(st);
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte", {24'd0, d}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
          chk("parity", {31'd0, p}, {31'd0, ^e});
`endif
        end
        @(negedge clk);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int w;
    w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !tx_busy && !mon_busy) break;
      @(negedge clk);
    end
    chk("drain", {31'd0, exp_q.size() == 0 && !tx_busy},
        32'd1);
  endtask

  task automatic chk_gaps(input string tag, input int n);
    chk({tag, "_frames"}, starts.size(), n);
    for (int i = 1; i < starts.size(); i++) begin
      chk({tag, "_gap"}, starts[i] - starts[i-1], FRAME);
    end
  endtask

  initial begin : stim
    int n0;
    int lows;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of bit 1 (a 0) of 0xA5
    push(8'hA5);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_a5_bit1", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", {31'd0, tx}, 32'd1);
    chk("async_level", {29'd0, fifo_level}, 32'd0);
    chk("async_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_spurious_start", lows, 0);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    mon_en = 1'b1;

    // single byte: latency and busy timing
    starts.delete();
    push(8'h35);
    n0 = cyc;
    tx_valid = 1'b0;
    while (cyc < n0 + FRAME) @(negedge clk);
    chk("busy_last", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    chk("busy_fall", {31'd0, tx_busy}, 32'd0);
    drain();
    chk("single_frames", starts.size(), 1);
    if (starts.size() > 0) chk("latency", starts[0] - n0, 1);

    // back-to-back with valid held high
    starts.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    push(8'hAA);
    tx_valid = 1'b0;
    drain();
    chk_gaps("b2b", 4);

    // FIFO full: six bytes, source holds the blocked one
    starts.delete();
    got_cnt = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h66);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, tx_ready}, 32'd0);
    push(8'h77);
    tx_valid = 1'b0;
    drain();
    chk("full_count", got_cnt, 6);
    chk_gaps("full", 6);

    // push on the same edge as the STOP-end pop
    starts.delete();
    push(8'h81);
    n0 = cyc;
    push(8'h42);
    push(8'hC3);
    tx_valid = 1'b0;
    while (cyc < n0 + FRAME) @(negedge clk);
    chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
    push(8'h3C);
    tx_valid = 1'b0;
    chk("pp_edge", cyc - n0, FRAME + 1);
    chk("pp_level_after", {29'd0, fifo_level}, 32'd2);
    drain();
    chk_gaps("pp", 4);

`ifdef UART_TX_PARITY_EN
    starts.delete();
    push(8'h07);
    push(8'h03);
    tx_valid = 1'b0;
    drain();
    chk_gaps("par", 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
